// File: rtl/sr_ff.sv
// Clocked set/reset flip-flop bank with a synchronous active-high reset.
// Each bit resolves its own S/R command; the S=R=1 case follows CONFLICT_MODE.
module sr_ff #(
   parameter int unsigned     WIDTH         = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter int unsigned     CONFLICT_MODE = 0
) (
   input  logic [WIDTH-1:0] S_in,
   input  logic [WIDTH-1:0] R_in,
   input  logic             CLK,
   input  logic             rst_in,
   output logic [WIDTH-1:0] Q_out
);

   if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
      $error("sr_ff: WIDTH must be in 1..64");
   end

   logic [WIDTH-1:0] set_bits;
   logic [WIDTH-1:0] clr_bits;
   logic [WIDTH-1:0] conf_bits;
   logic [WIDTH-1:0] idle_bits;
   logic [WIDTH-1:0] conf_val;
   logic [WIDTH-1:0] q_next;

   // Per-bit command decode; out-of-range modes fall back to hold.
   always_comb begin
      set_bits  = S_in & ~R_in;
      clr_bits  = ~S_in & R_in;
      conf_bits = S_in & R_in;
      idle_bits = ~(S_in | R_in);
      conf_val  = Q_out;
      case (CONFLICT_MODE)
         1:       conf_val = '1;
         2:       conf_val = '0;
         3:       conf_val = ~Q_out;
         default: conf_val = Q_out;
      endcase
      q_next = (Q_out & idle_bits) | set_bits | (conf_val & conf_bits);
      q_next = q_next & ~clr_bits;
   end

   // Reset takes priority over any pending command.
   always_ff @(posedge CLK) begin
      if (rst_in) begin
         Q_out <= RESET_VALUE;
      end else begin
         Q_out <= q_next;
      end
   end

endmodule

// File: tb/tb_sr_ff.sv
// Scoreboard bench for sr_ff: one default build plus four 4-bit builds
// covering every conflict mode, driven by a shared directed vector table.
module tb_sr_ff;

   typedef struct packed {
      logic       rst;
      logic [3:0] s;
      logic [3:0] r;
      logic       e1;
      logic [3:0] et;
      logic [3:0] es;
      logic [3:0] er;
      logic [3:0] eh;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] s   = '0;
   logic [3:0] r   = '0;
   logic       q1;
   logic [3:0] qt, qs, qr, qh;

   vec_t vec_q[$];
   vec_t exp_q[$];
   int   total  = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   sr_ff u_d1 (.S_in(s[0]), .R_in(r[0]), .CLK(clk), .rst_in(rst), .Q_out(q1));

   sr_ff #(.WIDTH(4), .RESET_VALUE(4'b1010), .CONFLICT_MODE(3)) u_tog (
      .S_in(s), .R_in(r), .CLK(clk), .rst_in(rst), .Q_out(qt));

   sr_ff #(.WIDTH(4), .RESET_VALUE(4'b0000), .CONFLICT_MODE(1)) u_set (
      .S_in(s), .R_in(r), .CLK(clk), .rst_in(rst), .Q_out(qs));

   sr_ff #(.WIDTH(4), .RESET_VALUE(4'b1111), .CONFLICT_MODE(2)) u_rst (
      .S_in(s), .R_in(r), .CLK(clk), .rst_in(rst), .Q_out(qr));

   sr_ff #(.WIDTH(4), .RESET_VALUE(4'b0101), .CONFLICT_MODE(5)) u_hld (
      .S_in(s), .R_in(r), .CLK(clk), .rst_in(rst), .Q_out(qh));

   task automatic chk(input string name, input int idx, input logic [3:0] act,
                      input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s vec%0d: got %b expected %b", name, idx, act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic add(input logic rst_v, input logic [3:0] s_v, input logic [3:0] r_v,
                      input logic e1, input logic [3:0] et, input logic [3:0] es,
                      input logic [3:0] er, input logic [3:0] eh);
      vec_t v;
      v = '{rst_v, s_v, r_v, e1, et, es, er, eh};
      vec_q.push_back(v);
   endtask

   // Monitor: every rising edge retires the oldest issued command.
   int mon_idx = 0;
   always @(posedge clk) begin
      vec_t e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("q_default", mon_idx, {3'b000, q1}, {3'b000, e.e1});
         chk("q_toggle",  mon_idx, qt, e.et);
         chk("q_setwin",  mon_idx, qs, e.es);
         chk("q_rstwin",  mon_idx, qr, e.er);
         chk("q_illegal", mon_idx, qh, e.eh);
         mon_idx++;
      end
   end

   initial begin
      int n;
      //   rst  S        R        d1    tog      set      rst      hold
      add(1, 4'b0001, 4'b0000, 1'b0, 4'b1010, 4'b0000, 4'b1111, 4'b0101);
      add(0, 4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b0000, 4'b1111, 4'b0101);
      add(0, 4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b0000, 4'b1111, 4'b0101);
      add(0, 4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b0000, 4'b1111, 4'b0101);
      add(0, 4'b0001, 4'b0000, 1'b1, 4'b1011, 4'b0001, 4'b1111, 4'b0101);
      add(0, 4'b0000, 4'b0000, 1'b1, 4'b1011, 4'b0001, 4'b1111, 4'b0101);
      add(0, 4'b0000, 4'b0001, 1'b0, 4'b1010, 4'b0000, 4'b1110, 4'b0100);
      add(0, 4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b0000, 4'b1110, 4'b0100);
      add(0, 4'b0001, 4'b0000, 1'b1, 4'b1011, 4'b0001, 4'b1111, 4'b0101);
      add(0, 4'b0001, 4'b0001, 1'b1, 4'b1010, 4'b0001, 4'b1110, 4'b0101);
      add(0, 4'b0000, 4'b0001, 1'b0, 4'b1010, 4'b0000, 4'b1110, 4'b0100);
      add(0, 4'b0001, 4'b0001, 1'b0, 4'b1011, 4'b0001, 4'b1110, 4'b0100);
      add(0, 4'b0001, 4'b0000, 1'b1, 4'b1011, 4'b0001, 4'b1111, 4'b0101);
      add(1, 4'b0001, 4'b0000, 1'b0, 4'b1010, 4'b0000, 4'b1111, 4'b0101);
      add(0, 4'b0001, 4'b0000, 1'b1, 4'b1011, 4'b0001, 4'b1111, 4'b0101);
      add(1, 4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b0000, 4'b1111, 4'b0101);
      add(0, 4'b1100, 4'b0110, 1'b0, 4'b1100, 4'b1100, 4'b1001, 4'b1101);
      add(0, 4'b1111, 4'b1111, 1'b0, 4'b0011, 4'b1111, 4'b0000, 4'b1101);
      add(0, 4'b1111, 4'b1111, 1'b0, 4'b1100, 4'b1111, 4'b0000, 4'b1101);
      add(0, 4'b0000, 4'b0000, 1'b0, 4'b1100, 4'b1111, 4'b0000, 4'b1101);
      add(0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(0, 4'b1010, 4'b0101, 1'b0, 4'b1010, 4'b1010, 4'b1010, 4'b1010);
      add(0, 4'b0110, 4'b0011, 1'b0, 4'b1100, 4'b1110, 4'b1100, 4'b1110);

      // Driver: apply each vector on the falling edge and queue its response.
      n = vec_q.size();
      for (int i = 0; i < n; i++) begin
         vec_t v;
         v = vec_q[i];
         @(negedge clk);
         rst = v.rst;
         s   = v.s;
         r   = v.r;
         exp_q.push_back(v);
         // Vector 14 raises S after reset: output must not move before the edge.
         if (i == 14) begin
            #1;
            chk("latency_pre_edge", i, {3'b000, q1}, 4'b0000);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      s   = '0;
      r   = '0;

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
      end else begin
         passed++;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
